// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default sizes for the RAM access controller.
// Optional feature macro used by the controller: RAM_ACCESS_CTRL_WR_VERIFY_EN
// (adds a read-back VERIFY state after every store).
package ram_access_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam int unsigned DEF_RD_WAIT   = 1;
  // Wait counter width; covers RD_WAIT up to 15.
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    VERIFY
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Core-side load/store request and response channel.
// Signals:
//   req_valid/req_ready : request handshake (core -> controller)
//   req_we              : 1 = store, 0 = load
//   req_addr/req_wdata  : word address and store data
//   rsp_valid/rsp_ready : response handshake (controller -> core)
//   rsp_rdata/rsp_err   : load data and error flag
// Modports: master = core side, slave = controller side.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_W = ram_access_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = ram_access_pkg::DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ram_access_ctrl.sv
// Processor-side initiator for a single-port RAM with combinational read.
// Accepts one load/store at a time, drives the RAM port, returns one response
// per request with an error flag (out-of-range address, or failed write verify).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response channel (ram_access_ctrl_if.slave)
//   busy       : controller not idle
//   ram_addr   : RAM address (add)
//   ram_din    : RAM write data (datain)
//   ram_we     : RAM write enable (en)
//   ram_dout   : RAM read data (dataout)
// Optional feature: define RAM_ACCESS_CTRL_WR_VERIFY_EN to read back every
// store for RD_WAIT cycles and flag a mismatch in rsp_err.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned RD_WAIT   = DEF_RD_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_WAIT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic [ADDR_W-1:0] w_ram_addr_nxt;
  logic [DATA_W-1:0] w_ram_din_nxt;
  logic              w_oor;

  assign w_oor = {1'b0, bus.req_addr} >= DEPTH_L;

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_ram_we    <= (w_state_nxt == WRITE);
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_din   <= w_ram_din_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_din_nxt   = r_ram_din;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_ram_addr_nxt = bus.req_addr;
          w_ram_din_nxt  = bus.req_wdata;
          if (w_oor) begin
            w_state_nxt     = RESP;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else if (bus.req_we) begin
            w_state_nxt = WRITE;
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end

      WRITE: begin
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
        w_state_nxt = VERIFY;
        w_cnt_nxt   = CNT_INIT;
`else
        w_state_nxt     = RESP;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
`endif
      end

      READ: begin
        if (r_cnt == '0) begin
          w_state_nxt     = RESP;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = ram_dout;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
      // Read back the word just written; r_ram_din still holds the store data.
      VERIFY: begin
        if (r_cnt == '0) begin
          w_state_nxt     = RESP;
          w_rsp_err_nxt   = (ram_dout != r_ram_din);
          w_rsp_rdata_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`endif

      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign busy          = r_busy;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_din       = r_ram_din;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two controllers (RD_WAIT=1 and RD_WAIT=3), each
// backed by a behavioural 256-word RAM with combinational read. A select
// signal routes the shared stimulus to one controller at a time.
module tb_ram_access_ctrl;

`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int SL1 = VFY ? 3 : 2;  // store latency, RD_WAIT=1
  localparam int SL3 = VFY ? 5 : 2;  // store latency, RD_WAIT=3

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        corrupt1 = 1'b0;

  ram_access_ctrl_if bus1 ();
  ram_access_ctrl_if bus3 ();

  logic        busy1, busy3, ram_we1, ram_we3;
  logic [15:0] ram_addr1, ram_addr3, ram_din1, ram_din3, ram_dout1, ram_dout3;

  assign bus1.req_valid = req_valid & ~sel;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.rsp_ready = rsp_ready & ~sel;
  assign bus3.req_valid = req_valid & sel;
  assign bus3.req_we    = req_we;
  assign bus3.req_addr  = req_addr;
  assign bus3.req_wdata = req_wdata;
  assign bus3.rsp_ready = rsp_ready & sel;

  ram_access_ctrl #(.RD_WAIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_dout(ram_dout1)
  );
  ram_access_ctrl #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3),
    .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_we(ram_we3), .ram_dout(ram_dout3)
  );

  // Behavioural RAMs; corrupt1 forces reads of the first RAM to zero.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  always @(posedge clk) begin
    if (ram_we1 && ram_addr1 < 16'd256) mem1[ram_addr1[7:0]] <= ram_din1;
    if (ram_we3 && ram_addr3 < 16'd256) mem3[ram_addr3[7:0]] <= ram_din3;
  end
  assign ram_dout1 = corrupt1 ? 16'h0000 : mem1[ram_addr1[7:0]];
  assign ram_dout3 = mem3[ram_addr3[7:0]];

  // Observed signals of the selected controller.
  logic        w_req_ready, w_rsp_valid, w_rsp_err, w_busy, w_ram_we;
  logic [15:0] w_rsp_rdata, w_ram_addr, w_ram_din;
  assign w_req_ready = sel ? bus3.req_ready : bus1.req_ready;
  assign w_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign w_rsp_err   = sel ? bus3.rsp_err   : bus1.rsp_err;
  assign w_rsp_rdata = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
  assign w_busy      = sel ? busy3     : busy1;
  assign w_ram_we    = sel ? ram_we3   : ram_we1;
  assign w_ram_addr  = sel ? ram_addr3 : ram_addr1;
  assign w_ram_din   = sel ? ram_din3  : ram_din1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(w_req_ready), 32'(1));
    chk({tag, "_rsp_valid"}, 32'(w_rsp_valid), 32'(0));
    chk({tag, "_rsp_err"},   32'(w_rsp_err),   32'(0));
    chk({tag, "_rsp_rdata"}, 32'(w_rsp_rdata), 32'(0));
    chk({tag, "_busy"},      32'(w_busy),      32'(0));
    chk({tag, "_ram_we"},    32'(w_ram_we),    32'(0));
    chk({tag, "_ram_addr"},  32'(w_ram_addr),  32'(0));
    chk({tag, "_ram_din"},   32'(w_ram_din),   32'(0));
  endtask

  // One full transaction, called at a negedge with the controller idle.
  // lat counts cycles from the accept edge to the first cycle with rsp_valid.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic err, output logic [15:0] rdata,
                         output int pulses, output logic [15:0] we_addr, output logic [15:0] we_din);
    int guard;
    lat = 0; err = 1'b0; rdata = '0; pulses = 0; we_addr = '0; we_din = '0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!w_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!w_req_ready) begin
      chk("accept_timeout", 32'(w_req_ready), 32'(1));
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!w_rsp_valid && lat < 40) begin
      if (w_ram_we) begin
        pulses++;
        we_addr = w_ram_addr;
        we_din  = w_ram_din;
      end
      @(negedge clk);
      lat++;
    end
    if (w_ram_we) pulses++;
    err   = w_rsp_err;
    rdata = w_rsp_rdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        corrupt;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat, pulses;
    logic        err;
    logic [15:0] rdata, we_addr, we_din;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end

    vecs[0]  = '{1'b1, 16'h0010, 16'hA5C3, 1'b0, 1'b0, 16'h0000, SL1, 1};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 2,   0};
    vecs[2]  = '{1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0000, 1,   0};
    vecs[3]  = '{1'b1, 16'h00FF, 16'h5A5A, 1'b0, 1'b0, 16'h0000, SL1, 1};
    vecs[4]  = '{1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 2,   0};
    vecs[5]  = '{1'b1, 16'hFFFF, 16'h1111, 1'b0, 1'b1, 16'h0000, 1,   0};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2,   0};
    vecs[7]  = '{1'b1, 16'h0030, 16'h1234, 1'b1, VFY,  16'h0000, SL1, 1};
    vecs[8]  = '{1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h1234, 2,   0};
    vecs[9]  = '{1'b1, 16'h0100, 16'hDEAD, 1'b0, 1'b1, 16'h0000, 1,   0};
    vecs[10] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 2,   0};

    // Reset values, during and after reset.
    @(negedge clk);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    // Table-driven transactions on the RD_WAIT=1 controller.
    for (int i = 0; i < 11; i++) begin
      corrupt1 = vecs[i].corrupt;
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rdata, pulses, we_addr, we_din);
      corrupt1 = 1'b0;
      chk($sformatf("v%0d_latency", i), 32'(lat),    32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rsp_err", i), 32'(err),    32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i),   32'(rdata),  32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_we_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses == 1) begin
        chk($sformatf("v%0d_we_addr", i), 32'(we_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_we_din", i),  32'(we_din),  32'(vecs[i].wdata));
      end
      chk($sformatf("v%0d_post_rsp_valid", i), 32'(w_rsp_valid), 32'(0));
      chk($sformatf("v%0d_post_req_ready", i), 32'(w_req_ready), 32'(1));
    end

    // Back-pressure: response held 5 cycles while a second request waits.
    req_we = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_first_valid", 32'(w_rsp_valid), 32'(1));
    req_addr = 16'h00FF; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_rsp_valid", k), 32'(w_rsp_valid), 32'(1));
      chk($sformatf("bp_hold%0d_rdata", k),     32'(w_rsp_rdata), 32'(16'hA5C3));
      chk($sformatf("bp_hold%0d_req_ready", k), 32'(w_req_ready), 32'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_rsp_valid", 32'(w_rsp_valid), 32'(0));
    chk("bp_after_hs_req_ready", 32'(w_req_ready), 32'(1));
    @(negedge clk);
    chk("bp_second_req_ready", 32'(w_req_ready), 32'(0));
    chk("bp_second_busy",      32'(w_busy),      32'(1));
    chk("bp_second_no_early",  32'(w_rsp_valid), 32'(0));
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(w_rsp_valid), 32'(1));
    chk("bp_second_rdata", 32'(w_rsp_rdata), 32'(16'h5A5A));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_second_done", 32'(w_rsp_valid), 32'(0));

    // Reset asserted while WRITE is driving the RAM.
    req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h7777; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_we_before", 32'(w_ram_we), 32'(1));
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid_write");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rsp%0d", k), 32'(w_rsp_valid), 32'(0));
    end
    run_txn(1'b0, 16'h0020, 16'h0000, lat, err, rdata, pulses, we_addr, we_din);
    chk("rst_aborted_write_rdata", 32'(rdata), 32'(0));

    // RD_WAIT=3 controller.
    sel = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 16'h0010, 16'hA5C3, lat, err, rdata, pulses, we_addr, we_din);
    chk("rw3_store_latency", 32'(lat), 32'(SL3));
    chk("rw3_store_err",     32'(err), 32'(0));
    run_txn(1'b0, 16'h0010, 16'h0000, lat, err, rdata, pulses, we_addr, we_din);
    chk("rw3_load_latency", 32'(lat),   32'(4));
    chk("rw3_load_rdata",   32'(rdata), 32'(16'hA5C3));
    run_txn(1'b0, 16'h0100, 16'h0000, lat, err, rdata, pulses, we_addr, we_din);
    chk("rw3_oor_latency", 32'(lat), 32'(1));
    chk("rw3_oor_err",     32'(err), 32'(1));
    sel = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
